// File: rtl/seg7_scan_controller.sv
// Four-digit seven-segment sequencer: double-dabble binary-to-BCD converter plus a free-running anode scan.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits during their scan slot).
module seg7_scan_controller #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  data_digit1,
  output logic [3:0]  data_digit2,
  output logic [3:0]  data_digit3,
  output logic [3:0]  data_digit4,
  output logic [1:0]  refresh_counter,
  output logic [3:0]  anode_n
);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [13:0] r_bin;
  logic [15:0] r_scratch;
  logic [3:0]  r_shiftCount;
  logic        r_ovfPending;
  logic        r_overflow;
  logic [3:0]  r_digit1;
  logic [3:0]  r_digit2;
  logic [3:0]  r_digit3;
  logic [3:0]  r_digit4;
  logic [15:0] r_prescale;
  logic [1:0]  r_refresh;
  logic [3:0]  r_anode;

  logic [13:0] w_clamped;
  logic [15:0] w_adjusted;
  logic        w_prescaleWrap;
  logic [1:0]  w_nextRefresh;
  logic [3:0]  w_nextAnode;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (load) w_nextState = CONVERT;
      CONVERT: if (r_shiftCount == 4'd13) w_nextState = UPDATE;
      UPDATE:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign w_clamped = (value > 14'd9999) ? 14'd9999 : value;

  // Add-3 correction on every nibble before the shift, so one shift step costs one cycle.
  always_comb begin
    w_adjusted = r_scratch;
    for (int i = 0; i < 4; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) w_adjusted[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin        <= '0;
      r_scratch    <= '0;
      r_shiftCount <= '0;
      r_ovfPending <= 1'b0;
      r_overflow   <= 1'b0;
      r_digit1     <= '0;
      r_digit2     <= '0;
      r_digit3     <= '0;
      r_digit4     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_bin        <= w_clamped;
            r_ovfPending <= (value > 14'd9999);
            r_scratch    <= '0;
            r_shiftCount <= '0;
          end
        end
        CONVERT: begin
          r_scratch    <= {w_adjusted[14:0], r_bin[13]};
          r_bin        <= {r_bin[12:0], 1'b0};
          r_shiftCount <= r_shiftCount + 4'd1;
        end
        UPDATE: begin
          r_digit1   <= r_scratch[3:0];
          r_digit2   <= r_scratch[7:4];
          r_digit3   <= r_scratch[11:8];
          r_digit4   <= r_scratch[15:12];
          r_overflow <= r_ovfPending;
        end
        default: ;
      endcase
    end
  end

  assign w_prescaleWrap = (r_prescale == 16'(REFRESH_DIV - 1));
  assign w_nextRefresh  = w_prescaleWrap ? r_refresh + 2'd1 : r_refresh;

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] w_blank;
  assign w_blank[0] = 1'b0;
  assign w_blank[3] = (r_digit4 == 4'd0);
  assign w_blank[2] = w_blank[3] && (r_digit3 == 4'd0);
  assign w_blank[1] = w_blank[2] && (r_digit2 == 4'd0);
`endif

  // Anode pattern is computed for the slot the next edge lands in, keeping it aligned with refresh_counter.
  always_comb begin
    w_nextAnode = ~(4'b0001 << w_nextRefresh);
`ifdef LEADING_ZERO_BLANK_EN
    if (w_blank[w_nextRefresh]) w_nextAnode = 4'b1111;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale <= '0;
      r_refresh  <= '0;
      r_anode    <= 4'b1110;
    end else begin
      r_prescale <= w_prescaleWrap ? 16'd0 : r_prescale + 16'd1;
      r_refresh  <= w_nextRefresh;
      r_anode    <= w_nextAnode;
    end
  end

  assign busy            = (r_state != IDLE);
  assign overflow        = r_overflow;
  assign data_digit1     = r_digit1;
  assign data_digit2     = r_digit2;
  assign data_digit3     = r_digit3;
  assign data_digit4     = r_digit4;
  assign refresh_counter = r_refresh;
  assign anode_n         = r_anode;

endmodule
